// File: rtl/fmm_sync_monitor_if.sv
// TTC-side strobes and FMM status outputs of the sync monitor, grouped as one bundle.
// The master drives the TTC/control strobes; the slave (the monitor) drives status.
interface fmm_sync_monitor_if #(
  parameter int BXN_WIDTH     = 12,
  parameter int ERR_CNT_WIDTH = 16
);
  logic                     ttc_bx0;
  logic                     ttc_resync;
  logic                     dont_wait;
  logic                     err_cnt_clr;
  logic                     fmm_trig_stop;
  logic [2:0]               fmm_state;
  logic [BXN_WIDTH-1:0]     bxn_cnt;
  logic                     sync_err;
  logic                     bx0_timeout;
  logic [ERR_CNT_WIDTH-1:0] bx0_err_cnt;

  modport master (
    output ttc_bx0, ttc_resync, dont_wait, err_cnt_clr,
    input  fmm_trig_stop, fmm_state, bxn_cnt, sync_err, bx0_timeout, bx0_err_cnt
  );

  modport slave (
    input  ttc_bx0, ttc_resync, dont_wait, err_cnt_clr,
    output fmm_trig_stop, fmm_state, bxn_cnt, sync_err, bx0_timeout, bx0_err_cnt
  );
endinterface

// File: rtl/fmm_sync_monitor.sv
// FMM sync monitor: locks a local BX counter to TTC BX0, checks every later BX0 against it,
// counts sync errors and raises fmm_trig_stop whenever the block is not in RUN.
module fmm_sync_monitor #(
  parameter int BXN_MAX        = 3563,
  parameter int BXN_WIDTH      = 12,
  parameter int BXN_PRESET     = 0,
  parameter int STARTUP_CYCLES = 16,
  parameter int BX0_TIMEOUT    = 8192,
  parameter int ERR_LIMIT      = 3,
  parameter int ERR_CNT_WIDTH  = 16
) (
  input logic               clock,
  input logic               reset_i,
  fmm_sync_monitor_if.slave bus
);

  typedef enum logic [2:0] {
    ST_STARTUP = 3'd0,
    ST_RESYNC  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RUN     = 3'd3,
    ST_OOS     = 3'd4
  } state_t;

  localparam int SU_W = $clog2(STARTUP_CYCLES + 1);
  localparam int TO_W = $clog2(BX0_TIMEOUT + 1);
  localparam int CB_W = $clog2(ERR_LIMIT + 1);
  localparam logic [BXN_WIDTH-1:0] BXN_PRE = BXN_WIDTH'(BXN_PRESET);
  // Counter value in the cycle that carries a well-timed BX0
  localparam logic [BXN_WIDTH-1:0] BXN_EXP = BXN_WIDTH'((BXN_PRESET + BXN_MAX) % (BXN_MAX + 1));

  logic                     reset_q;
  state_t                   state_q, state_d;
  logic [BXN_WIDTH-1:0]     bxn_q, bxn_d, bxn_inc_s;
  logic [SU_W-1:0]          su_cnt_q, su_cnt_d;
  logic [TO_W-1:0]          to_cnt_q, to_cnt_d;
  logic [CB_W-1:0]          bad_q, bad_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                     sync_err_q, sync_err_d;
  logic                     tmo_q, tmo_d;
  logic                     stop_q;
  logic                     evt_s, good_s, tmo_set_s;

  // Next-state logic for the FSM, BX counter, timers and error bookkeeping
  always_comb begin
    state_d    = state_q;
    su_cnt_d   = su_cnt_q;
    to_cnt_d   = {TO_W{1'b0}};
    bad_d      = bad_q;
    err_cnt_d  = err_cnt_q;
    sync_err_d = sync_err_q;
    tmo_d      = tmo_q;
    tmo_set_s  = 1'b0;
    bxn_inc_s  = (bxn_q == BXN_WIDTH'(BXN_MAX)) ? {BXN_WIDTH{1'b0}} : bxn_q + BXN_WIDTH'(1);

    if (state_q == ST_RUN) begin
      evt_s  = bus.ttc_bx0 != (bxn_q == BXN_EXP);
      good_s = bus.ttc_bx0 && (bxn_q == BXN_EXP);
    end else begin
      evt_s  = 1'b0;
      good_s = 1'b0;
    end

    if (state_q == ST_RUN || state_q == ST_OOS) begin
      bxn_d = bxn_inc_s;
    end else if (state_q == ST_RESYNC || bus.ttc_bx0) begin
      bxn_d = BXN_PRE;
    end else begin
      bxn_d = bxn_inc_s;
    end

    // A mismatch coinciding with err_cnt_clr is dropped entirely
    if (state_q != ST_RUN || good_s) begin
      bad_d = {CB_W{1'b0}};
    end else if (evt_s && !bus.err_cnt_clr && bad_q < CB_W'(ERR_LIMIT)) begin
      bad_d = bad_q + CB_W'(1);
    end else begin
      bad_d = bad_q;
    end

    case (state_q)
      ST_STARTUP: begin
        if (su_cnt_q == SU_W'(STARTUP_CYCLES - 1)) begin
          state_d = ST_WAIT;
        end else begin
          su_cnt_d = su_cnt_q + SU_W'(1);
        end
      end
      ST_RESYNC: state_d = bus.ttc_bx0 ? ST_RUN : ST_WAIT;
      ST_WAIT: begin
        to_cnt_d  = (to_cnt_q == TO_W'(BX0_TIMEOUT)) ? to_cnt_q : to_cnt_q + TO_W'(1);
        tmo_set_s = (to_cnt_q == TO_W'(BX0_TIMEOUT - 1));
        if (bus.ttc_bx0 || bus.dont_wait) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RUN: begin
        if (evt_s && !bus.err_cnt_clr && (int'(bad_q) + 1 >= ERR_LIMIT)) begin
          state_d = ST_OOS;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_OOS:  state_d = ST_OOS;
      default: state_d = ST_STARTUP;
    endcase

    if (bus.ttc_resync) begin
      state_d = ST_RESYNC;
      bxn_d   = BXN_PRE;
    end else begin
      state_d = state_d;
    end

    if (bus.err_cnt_clr) begin
      err_cnt_d  = {ERR_CNT_WIDTH{1'b0}};
      sync_err_d = 1'b0;
      tmo_d      = 1'b0;
    end else begin
      if (evt_s) begin
        err_cnt_d  = (err_cnt_q == {ERR_CNT_WIDTH{1'b1}}) ? err_cnt_q : err_cnt_q + ERR_CNT_WIDTH'(1);
        sync_err_d = 1'b1;
      end else begin
        err_cnt_d = err_cnt_q;
      end
      if (tmo_set_s) begin
        tmo_d = 1'b1;
      end else begin
        tmo_d = tmo_d;
      end
    end
  end

  // State registers; reset_i is registered once, so reset acts one cycle late
  always_ff @(posedge clock) begin
    reset_q <= reset_i;
    if (reset_q) begin
      state_q    <= ST_STARTUP;
      bxn_q      <= BXN_PRE;
      su_cnt_q   <= {SU_W{1'b0}};
      to_cnt_q   <= {TO_W{1'b0}};
      bad_q      <= {CB_W{1'b0}};
      err_cnt_q  <= {ERR_CNT_WIDTH{1'b0}};
      sync_err_q <= 1'b0;
      tmo_q      <= 1'b0;
      stop_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      bxn_q      <= bxn_d;
      su_cnt_q   <= su_cnt_d;
      to_cnt_q   <= to_cnt_d;
      bad_q      <= bad_d;
      err_cnt_q  <= err_cnt_d;
      sync_err_q <= sync_err_d;
      tmo_q      <= tmo_d;
      stop_q     <= (state_q != ST_RUN);
    end
  end

  assign bus.fmm_trig_stop = stop_q;
  assign bus.fmm_state     = state_q;
  assign bus.bxn_cnt       = bxn_q;
  assign bus.sync_err      = sync_err_q;
  assign bus.bx0_timeout   = tmo_q;
  assign bus.bx0_err_cnt   = err_cnt_q;

endmodule
